// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// Each request is held for a fixed number of wait states, then answered once.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic        write_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic        err_reg;

  logic        accept;
  logic        eff_write;
  logic [31:0] eff_addr;
  logic [31:0] eff_wdata;
  logic [3:0]  eff_be;
  logic [AW-1:0] eff_idx;
  logic        eff_err;
  logic        enter_resp;
  logic        commit;
  logic        load_fire;

  assign accept = req_valid_i && (state_reg == ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_reg == ST_IDLE);
    rsp_valid_o = (state_reg == ST_RESP);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_reg <= 1'b0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
      be_reg    <= 4'd0;
    end else if (accept) begin
      write_reg <= req_write_i;
      addr_reg  <= req_addr_i;
      wdata_reg <= req_wdata_i;
      be_reg    <= req_be_i;
    end
  end

  // With zero wait states RESP is entered on the accept edge itself, before
  // the capture registers hold the request, so the live inputs are used there.
  always_comb begin
    if (state_reg == ST_IDLE) begin
      eff_write = req_write_i;
      eff_addr  = req_addr_i;
      eff_wdata = req_wdata_i;
      eff_be    = req_be_i;
    end else begin
      eff_write = write_reg;
      eff_addr  = addr_reg;
      eff_wdata = wdata_reg;
      eff_be    = be_reg;
    end
  end

  assign eff_idx    = eff_addr[AW+1:2];
  assign eff_err    = (eff_addr[1:0] != 2'b00) || (eff_addr[31:AW+2] != '0);
  assign enter_resp = !rst_i && (state_reg != ST_RESP) && (state_next == ST_RESP);
  assign commit     = enter_resp && eff_write && !eff_err;
  assign load_fire  = enter_resp && !eff_write && !eff_err;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else if (enter_resp) begin
      err_reg <= eff_err;
    end
  end

  assign rsp_err_o = err_reg;

  // One byte-wide RAM per lane so byte enables map onto plain writes.
  // Memory is never reset; only the read register is.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_reg;

      always_ff @(posedge clk_i) begin
        if (commit && eff_be[gi]) begin
          mem[eff_idx] <= eff_wdata[8*gi +: 8];
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rd_reg <= 8'h00;
        end else if (enter_resp) begin
          rd_reg <= load_fire ? mem[eff_idx] : 8'h00;
        end
      end

      assign rsp_rdata_o[8*gi +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised scoreboard bench for data_mem_responder, plus a zero-wait instance
// exercised with directed requests.
module tb_data_mem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_z, req_ready_z, req_write_z;
  logic [31:0] req_addr_z, req_wdata_z;
  logic [3:0]  req_be_z;
  logic        rsp_valid_z, rsp_ready_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut_z (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid_z), .req_ready_o(req_ready_z), .req_write_i(req_write_z),
    .req_addr_i(req_addr_z), .req_wdata_i(req_wdata_z), .req_be_i(req_be_z),
    .rsp_valid_o(rsp_valid_z), .rsp_ready_i(rsp_ready_z),
    .rsp_rdata_o(rsp_rdata_z), .rsp_err_o(rsp_err_z)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          bp_cnt     = 0;
  int          rsp_num    = 0;
  bit          seen       = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response-ready driver: random, or held low for bp_cnt valid cycles.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_cnt > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) bp_cnt--;
      end else begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: compares every presented response cycle with the queue head.
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rsp: got valid rdata=0x%08h err=%0b expected no response",
                 rsp_rdata, rsp_err);
      end else begin
        if (!seen) check("latency", 32'(cyc), 32'(sb_q[0].acc + W));
        check("rdata", rsp_rdata, sb_q[0].rdata);
        check("err", {31'd0, rsp_err}, {31'd0, sb_q[0].err});
        check("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (rsp_ready) begin
          rsp_num++;
          $display("rsp %0d: rdata=0x%08h err=%0b", rsp_num, rsp_rdata, rsp_err);
          void'(sb_q.pop_front());
          seen = 1'b0;
        end else begin
          seen = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    logic        err;
    int          idx;
    int          n;
    logic [31:0] w;
    err = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
    idx = int'(addr >> 2) % DEPTH;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
    end else begin
      e.err = err;
      e.acc = cyc + 1;
      if (err || wr) begin
        e.rdata = 32'd0;
      end else begin
        e.rdata = model_mem[idx];
      end
      if (wr && !err) begin
        w = model_mem[idx];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        model_mem[idx] = w;
      end
      sb_q.push_back(e);
      $display("req: %s addr=0x%08h wdata=0x%08h be=%04b", wr ? "ST" : "LD", addr, wdata, be);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || rsp_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_req_z(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    check("z_ready_idle", {31'd0, req_ready_z}, 32'd1);
    req_valid_z = 1'b1;
    req_write_z = wr;
    req_addr_z  = addr;
    req_wdata_z = wdata;
    req_be_z    = be;
    @(posedge clk);
    #1 req_valid_z = 1'b0;
    @(negedge clk);
    check("z_valid_lat0", {31'd0, rsp_valid_z}, 32'd1);
    check("z_rdata", rsp_rdata_z, exp_rdata);
    check("z_err", {31'd0, rsp_err_z}, {31'd0, exp_err});
    check("z_ready_busy", {31'd0, req_ready_z}, 32'd0);
    $display("z %s addr=0x%08h: rdata=0x%08h err=%0b", wr ? "ST" : "LD", addr, rsp_rdata_z, rsp_err_z);
    rsp_ready_z = 1'b1;
    @(posedge clk);
    #1 rsp_ready_z = 1'b0;
    @(negedge clk);
    check("z_valid_clear", {31'd0, rsp_valid_z}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        wr;
    logic [31:0] addr;
    int          r;
    int          idx;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    req_valid_z = 1'b0; req_write_z = 1'b0; req_addr_z = '0; req_wdata_z = '0; req_be_z = '0;
    rsp_ready_z = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);

    for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 32'h10, 32'h0, 4'h0);

    issue(1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 32'h20, 32'h0, 4'h0);
    issue(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000);
    issue(1'b0, 32'h20, 32'h0, 4'h0);

    issue(1'b0, 32'h0000_0402, 32'h0, 4'h0);
    issue(1'b1, 32'h0000_0400, 32'hCAFEF00D, 4'hF);
    issue(1'b0, 32'h0000_0000, 32'h0, 4'h0);

    drain();
    bp_cnt = 5;
    issue(1'b0, 32'h10, 32'h0, 4'h0);
    drain();

    for (int i = 0; i < 150; i++) begin
      wr  = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 9);
      idx = $urandom_range(0, 15);
      if (r == 0)      addr = 32'(idx * 4 + $urandom_range(1, 3));
      else if (r == 1) addr = 32'h400 + 32'($urandom_range(0, 255) * 4);
      else if (r == 2) addr = $urandom | 32'h8000_0000;
      else             addr = 32'(idx * 4);
      issue(wr, addr, $urandom, 4'($urandom_range(0, 15)));
    end
    drain();

    // Store aborted by reset while waiting: no response, memory untouched.
    @(negedge clk);
    check("ready_before_abort", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'd0, req_ready}, 32'd1);
    check("valid_after_abort", {31'd0, rsp_valid}, 32'd0);
    repeat (5) @(negedge clk);
    issue(1'b0, 32'h8, 32'h0, 4'h0);
    drain();

    do_req_z(1'b1, 32'h4,  32'h12345678, 4'hF,    32'h0,        1'b0);
    do_req_z(1'b0, 32'h4,  32'h0,        4'h0,    32'h12345678, 1'b0);
    do_req_z(1'b1, 32'h4,  32'hA5A5A5A5, 4'b1000, 32'h0,        1'b0);
    do_req_z(1'b0, 32'h4,  32'h0,        4'h0,    32'hA5345678, 1'b0);
    do_req_z(1'b0, 32'h40, 32'h0,        4'h0,    32'h0,        1'b1);
    do_req_z(1'b1, 32'h52, 32'hFFFFFFFF, 4'hF,    32'h0,        1'b1);
    do_req_z(1'b0, 32'h4,  32'h0,        4'h0,    32'hA5345678, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
